// File: rtl/video_scandbl.sv
// Line-doubling scan converter: captures TV-rate lines into a pair of ping-pong banks and replays each twice at VGA rate.
// Optional build macro VIDEO_SCANLINES_EN enables dimming of the second repetition when scanlines_on is set.
module video_scandbl #(
  parameter int PIX_W    = 6,
  parameter int LINE_LEN = 448,
  parameter int HS_LEN   = 52
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync_start,
  input  logic             scanin_start,
  input  logic             scanout_start,
  input  logic             in_stb,
  input  logic             out_stb,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             scanlines_on,
  output logic [PIX_W-1:0] pix_out,
  output logic             vga_hsync,
  output logic             second_line
);

  localparam int AW = $clog2(LINE_LEN + 1);
  localparam int HW = $clog2(HS_LEN + 1);

  logic [PIX_W-1:0] mem0 [0:LINE_LEN-1];
  logic [PIX_W-1:0] mem1 [0:LINE_LEN-1];

  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] cnt0;
  logic [AW-1:0] cnt1;
  logic [HW-1:0] hs_cnt;

  logic [AW-1:0]    wa;
  logic [AW-1:0]    ra;
  logic             wr_en;
  logic             rd_bank;
  logic [AW-1:0]    rd_cnt;
  logic [PIX_W-1:0] rd_data;
  logic [PIX_W-1:0] pix_nxt;

`ifdef VIDEO_SCANLINES_EN
  localparam int FW = PIX_W / 3;

  function automatic logic [PIX_W-1:0] halve(input logic [PIX_W-1:0] v);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*FW +: FW] = v[i*FW +: FW] >> 1;
    return r;
  endfunction
`else
  logic unused_scanlines;
  assign unused_scanlines = scanlines_on;
`endif

  // A toggle in this cycle makes the just-filled bank readable immediately.
  always_comb begin
    wa      = scanin_start ? '0 : wr_addr;
    wr_en   = in_stb && (wa < AW'(LINE_LEN));
    ra      = scanout_start ? '0 : rd_addr;
    rd_bank = hsync_start ? wr_bank : ~wr_bank;
    if (hsync_start)  rd_cnt = wr_addr;
    else if (rd_bank) rd_cnt = cnt1;
    else              rd_cnt = cnt0;
    rd_data = '0;
    pix_nxt = '0;
    if (ra < rd_cnt) begin
      rd_data = rd_bank ? mem1[ra] : mem0[ra];
      pix_nxt = rd_data;
    end
`ifdef VIDEO_SCANLINES_EN
    if (scanlines_on && second_line) pix_nxt = halve(pix_nxt);
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_bank)  mem1[wa] <= pix_in;
    if (wr_en && !wr_bank) mem0[wa] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      cnt0        <= '0;
      cnt1        <= '0;
      hs_cnt      <= '0;
      pix_out     <= '0;
      vga_hsync   <= 1'b0;
      second_line <= 1'b0;
    end else begin
      if (hsync_start) begin
        wr_bank <= ~wr_bank;
        if (wr_bank) cnt1 <= wr_addr;
        else         cnt0 <= wr_addr;
      end

      if (wr_en)             wr_addr <= wa + AW'(1);
      else if (scanin_start) wr_addr <= '0;

      if (out_stb) begin
        rd_addr <= (ra < AW'(LINE_LEN)) ? ra + AW'(1) : ra;
        pix_out <= pix_nxt;
      end else if (scanout_start) begin
        rd_addr <= '0;
      end

      if (hsync_start)        second_line <= 1'b0;
      else if (scanout_start) second_line <= ~second_line;

      // hs_cnt counts the remaining high cycles; the pulse drops as it runs out.
      if (scanout_start) begin
        hs_cnt    <= HW'(HS_LEN);
        vga_hsync <= 1'b1;
      end else if (hs_cnt != '0) begin
        hs_cnt <= hs_cnt - HW'(1);
        if (hs_cnt == HW'(1)) vga_hsync <= 1'b0;
      end
    end
  end

endmodule

// File: doc/video_scandbl.md
VIDEO_SCANDBL -- requirements
Module: video_scandbl

Interface
REQ-001 SHALL have parameter PIX_W, default 6, pixel colour width in bits; multiple of 3, one equal field per R/G/B.
REQ-002 SHALL have parameter LINE_LEN, default 448, maximum stored samples per input line.
REQ-003 SHALL have parameter HS_LEN, default 52, VGA hsync pulse length in clk cycles.
REQ-004 SHALL have ports: clk in 1, single clock, 28 MHz.
REQ-005 SHALL have ports: rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: hsync_start in 1, one-cycle TV line boundary strobe.
REQ-007 SHALL have ports: scanin_start in 1, one-cycle start of input line capture.
REQ-008 SHALL have ports: scanout_start in 1, one-cycle start of output line, twice per TV line.
REQ-009 SHALL have ports: in_stb in 1, input sample enable; out_stb in 1, output sample enable.
REQ-010 SHALL have ports: pix_in in PIX_W, TV-rate pixel colour.
REQ-011 SHALL have ports: scanlines_on in 1, request dimming of second output line.
REQ-012 SHALL have ports: pix_out out PIX_W, VGA-rate pixel; vga_hsync out 1, active-high; second_line out 1, high during second repetition.

Function
REQ-013 SHALL hold two line buffers (banks) of LINE_LEN x PIX_W; write bank and read bank always differ.
REQ-014 SHALL toggle bank selection on hsync_start; a scanout_start in the same cycle reads the newly completed bank.
REQ-015 SHALL clear write address on scanin_start; in_stb writes pix_in at current address, then increments.
REQ-016 SHALL accept in_stb coincident with scanin_start as a write to address 0.
REQ-017 SHALL stop writing once write address reaches LINE_LEN; extra in_stb ignored, no wrap.
REQ-018 SHALL record per bank the count of samples written (0..LINE_LEN), latched at bank toggle.
REQ-019 SHALL clear read address on scanout_start; each out_stb reads one sample and increments, saturating at LINE_LEN.
REQ-020 SHALL update pix_out exactly 1 clk after out_stb, holding value between strobes.
REQ-021 SHALL output zero for reads at address >= recorded count of the read bank.
REQ-022 SHALL clear second_line on hsync_start and toggle it on each scanout_start not coincident with hsync_start.
REQ-023 SHALL assert vga_hsync for exactly HS_LEN clk starting the cycle after scanout_start; a new scanout_start restarts the count.

Reset
REQ-024 SHALL on rst_n low asynchronously force pix_out=0, vga_hsync=0, second_line=0, addresses=0, bank=0, both counts=0.
REQ-025 SHALL, on reset asserted mid-line, emit zero pixels until a full line is captured after release; buffer contents not cleared.

Configuration
REQ-026 SHALL with VIDEO_SCANLINES_EN defined: when scanlines_on=1 and second_line=1, each colour field of pix_out is right-shifted by 1 (halved).
REQ-027 SHALL with VIDEO_SCANLINES_EN undefined: both repetitions identical; scanlines_on ignored; no dimming logic synthesised.

Verification
REQ-028 SHALL cover: line of 448 ramp samples (value=index mod 64), toggle, two scanouts -> both output lines equal ramp, pix_out 1 clk after each out_stb.
REQ-029 SHALL cover: 500 in_stb in one line -> first 448 stored, reads 0..447 match, addresses beyond return 0.
REQ-030 SHALL cover: 100-sample line then 448 out_stb -> samples 0..99 reproduced, 100..447 output 0.
REQ-031 SHALL cover: scanout_start alone -> vga_hsync high exactly 52 clk; second scanout_start at clk 30 -> high 52 clk from restart.
REQ-032 SHALL cover: VIDEO_SCANLINES_EN, scanlines_on=1, pix_in=6'b111111 -> first line 6'b111111, second 6'b010101; macro undefined -> both 6'b111111.
REQ-033 SHALL cover: rst_n pulsed low mid-readout -> pix_out, vga_hsync, second_line 0 immediately; zero pixels until next full capture.
